// File: rtl/port_packet_streamer_pkg.sv
// port_packet_streamer_pkg: shared constants and FSM encoding for the output-port packet streamer.
//   Contents: packet header byte indices, minimum legal length, streamer FSM states.
package port_packet_streamer_pkg;
  localparam int LEN_IDX     = 0;
  localparam int DEST_ID_IDX = 1;
  localparam int MIN_LEN     = 2;
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH_LEN = 3'd1,
    CHECK     = 3'd2,
    STREAM    = 3'd3,
    FINISH    = 3'd4
  } state_t;
endpackage

// File: rtl/port_packet_streamer_skid_fifo.sv
// port_packet_streamer_skid_fifo: 2-entry skid FIFO absorbing read data while the port is stalled.
//   clk2, rst (async, active-low) | push, din : write side | pop, dout : read side (dout = head)
//   count : current occupancy 0..2
module port_packet_streamer_skid_fifo #(
  parameter int W = 9
) (
  input  logic         clk2,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic [1:0]   count
);
  logic [W-1:0] mem [2];
  logic rp, wp;
  assign dout = mem[rp];
  always_ff @(posedge clk2 or negedge rst)
    if (!rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rp     <= 1'b0;
      wp     <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wp] <= din;
        wp      <= !wp;
      end
      if (pop) rp <= !rp;
      count <= count + 2'(push) - 2'(pop);
    end
endmodule

// File: rtl/port_packet_streamer.sv
// port_packet_streamer: streams one buffered packet from unit memory onto a valid/ready output port.
//   clk2, rst (async, active-low)
//   read_en, raddr          : start request and slot, sampled in IDLE only
//   done, len_err           : 1-cycle completion pulse, len_err flags a rejected length
//   mem_rd_en/slot/byte     : memory read request; mem_rdata returns one cycle later
//   out_data/valid/ready/last : output port
//   Optional: define ROUTER_XSUM_EN to append an XOR checksum byte after each packet.
module port_packet_streamer
  import port_packet_streamer_pkg::*;
#(
  parameter int UWIDTH    = 8,
  parameter int PTR_SZ    = 2,
  parameter int PTR_IN_SZ = 4
) (
  input  logic                 clk2,
  input  logic                 rst,
  input  logic                 read_en,
  input  logic [PTR_SZ-1:0]    raddr,
  output logic                 done,
  output logic                 len_err,
  output logic                 mem_rd_en,
  output logic [PTR_SZ-1:0]    mem_slot,
  output logic [PTR_IN_SZ-1:0] mem_byte,
  input  logic [UWIDTH-1:0]    mem_rdata,
  output logic [UWIDTH-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_last
);
  state_t state;
  logic [PTR_SZ-1:0] slot;
  logic [PTR_IN_SZ:0] len, idx;
  logic iss, iss_last, iss_x, r_v, r_last, r_x;
  logic [1:0] count, count_next;
  logic [UWIDTH:0] head;
  logic [UWIDTH-1:0] acc, r_data;
  logic fifo_push, fifo_pop, accept, len_bad, can_iss, nxt_last, nxt_x;
`ifdef ROUTER_XSUM_EN
  localparam bit XS = 1'b1;
  always_ff @(posedge clk2 or negedge rst)
    if (!rst) acc <= '0;
    else if (state == CHECK) acc <= '0;
    else if (r_v && !r_x) acc <= acc ^ mem_rdata;
`else
  localparam bit XS = 1'b0;
  assign acc = '0;
`endif
  // r_* describe the read whose data is on mem_rdata this cycle; r_x marks the checksum slot
  assign r_data     = r_x ? acc : mem_rdata;
  // with an empty FIFO the returning byte is presented directly, giving the 2-cycle first-byte latency
  assign out_valid  = r_v || count != 2'd0;
  assign {out_last, out_data} = count != 2'd0 ? head : (r_v ? {r_last, r_data} : '0);
  assign accept     = out_valid && out_ready;
  assign fifo_pop   = count != 2'd0 && out_ready;
  assign fifo_push  = r_v && !(count == 2'd0 && out_ready);
  assign count_next = count + 2'(fifo_push) - 2'(fifo_pop);
  assign len_bad    = mem_rdata < UWIDTH'(MIN_LEN) || mem_rdata > UWIDTH'(2**PTR_IN_SZ);
  assign nxt_x      = XS && idx == len;
  assign nxt_last   = XS ? nxt_x : idx == len - 1'b1;
  // credit: a new read lands two cycles out, so FIFO entries plus the read still in flight must leave room
  assign can_iss    = state == STREAM && (idx < len || nxt_x) && count_next + 2'(iss) < 2'd2;
  port_packet_streamer_skid_fifo #(.W(UWIDTH + 1)) u_fifo (
    .clk2  (clk2),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({r_last, r_data}),
    .dout  (head),
    .count (count)
  );
  always_ff @(posedge clk2 or negedge rst)
    if (!rst) begin
      state     <= IDLE;
      slot      <= '0;
      len       <= '0;
      idx       <= '0;
      done      <= 1'b0;
      len_err   <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_slot  <= '0;
      mem_byte  <= '0;
      iss       <= 1'b0;
      iss_last  <= 1'b0;
      iss_x     <= 1'b0;
      r_v       <= 1'b0;
      r_last    <= 1'b0;
      r_x       <= 1'b0;
    end else begin
      done      <= 1'b0;
      len_err   <= 1'b0;
      mem_rd_en <= 1'b0;
      mem_slot  <= '0;
      mem_byte  <= '0;
      iss       <= 1'b0;
      iss_last  <= 1'b0;
      iss_x     <= 1'b0;
      r_v       <= iss;
      r_last    <= iss_last;
      r_x       <= iss_x;
      case (state)
        IDLE:
          if (read_en) begin
            slot      <= raddr;
            mem_rd_en <= 1'b1;
            mem_slot  <= raddr;
            mem_byte  <= PTR_IN_SZ'(LEN_IDX);
            state     <= FETCH_LEN;
          end
        FETCH_LEN: state <= CHECK;
        CHECK:
          if (len_bad) begin
            done    <= 1'b1;
            len_err <= 1'b1;
            state   <= FINISH;
          end else begin
            len       <= mem_rdata[PTR_IN_SZ:0];
            idx       <= (PTR_IN_SZ + 1)'(1);
            iss       <= 1'b1;
            mem_rd_en <= 1'b1;
            mem_slot  <= slot;
            state     <= STREAM;
          end
        STREAM: begin
          if (can_iss) begin
            idx       <= idx + 1'b1;
            iss       <= 1'b1;
            iss_last  <= nxt_last;
            iss_x     <= nxt_x;
            mem_rd_en <= !nxt_x;
            mem_slot  <= nxt_x ? '0 : slot;
            mem_byte  <= nxt_x ? '0 : idx[PTR_IN_SZ-1:0];
          end
          if (accept && out_last) begin
            done  <= 1'b1;
            state <= FINISH;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
